abs_diff_sad: RTL and testbench

Streaming, parametrised absolute-difference block that computes |a−b| per sample pair and reduces fixed-length blocks of samples to a sum of absolute differences (SAD) and a block maximum. It is the successor to the fixed 3-bit combinational abs-diff partitions: it is generalised in width and block length, pipelined, and has valid/ready flow control. Optional LSB truncation gives a compile-time approximate mode. It sits between the pixel/sample stream and the cost-compare logic.

---
 rtl/abs_diff_sad.sv | 116 +++++++++++
 tb/tb_abs_diff_sad.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/abs_diff_sad.sv
// abs_diff_sad: streaming |a-b| with per-block sum (SAD) and maximum.
// Two register stages: stage 1 holds |a-b| of the accepted pair, and
// stage 2 accumulates BLOCK_LEN diffs and then presents sad/max with
// valid/ready flow control. While a result is held and not taken, the
// whole pipeline freezes and in_ready drops.
// Compile-time option: define ABS_DIFF_APPROX_EN to zero the low
// APPROX_BITS of both operands before subtraction (approximate mode).
module abs_diff_sad #(
    parameter int WIDTH       = 8,
    parameter int BLOCK_LEN   = 16,
    parameter int APPROX_BITS = 2,
    localparam int SAD_W      = WIDTH + $clog2(BLOCK_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SAD_W-1:0] out_sad,
    output logic [WIDTH-1:0] out_max
);

`ifdef ABS_DIFF_APPROX_EN
    localparam bit APPROX_ON = 1'b1;
`else
    localparam bit APPROX_ON = 1'b0;
`endif
    localparam int DROP_BITS = APPROX_ON ? APPROX_BITS : 0;
    localparam logic [WIDTH-1:0] KEEP_MASK = {WIDTH{1'b1}} << DROP_BITS;
    localparam int CNT_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_LEN - 1);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               diff_v_q;
    logic [SAD_W-1:0]   acc_q, sum_d;
    logic [WIDTH-1:0]   mx_q, max_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               out_valid_q;
    logic [SAD_W-1:0]   out_sad_q;
    logic [WIDTH-1:0]   out_max_q;
    logic [WIDTH-1:0]   a_m, b_m;
    logic [SAD_W-1:0]   acc_base;
    logic [WIDTH-1:0]   mx_base;
    logic               stall;
    logic               last;

    // Flow control, operand masking, |a-b| and the stage-2 next values.
    always_comb begin
        stall    = out_valid_q & ~out_ready;
        in_ready = ~stall;
        a_m      = in_a & KEEP_MASK;
        b_m      = in_b & KEEP_MASK;
        diff_d   = (a_m >= b_m) ? (a_m - b_m) : (b_m - a_m);
        // In IDLE the running totals are known to be zero.
        acc_base = (state_q == IDLE) ? '0 : acc_q;
        mx_base  = (state_q == IDLE) ? '0 : mx_q;
        sum_d    = acc_base + SAD_W'(diff_q);
        max_d    = (diff_q > mx_base) ? diff_q : mx_base;
        last     = (cnt_q == CNT_LAST);
    end

    // Stage 1: capture |a-b| of each accepted pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            diff_q   <= '0;
            diff_v_q <= 1'b0;
        end else if (!stall) begin
            diff_v_q <= in_valid;
            if (in_valid) begin
                diff_q <= diff_d;
            end
        end
    end

    // Stage 2: block accumulator FSM with registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            mx_q        <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_sad_q   <= '0;
            out_max_q   <= '0;
        end else if (!stall) begin
            if (diff_v_q && last) begin
                out_sad_q   <= sum_d;
                out_max_q   <= max_d;
                out_valid_q <= 1'b1;
                acc_q       <= '0;
                mx_q        <= '0;
                cnt_q       <= '0;
                state_q     <= IDLE;
            end else begin
                out_valid_q <= 1'b0;
                if (diff_v_q) begin
                    acc_q   <= sum_d;
                    mx_q    <= max_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    state_q <= ACCUM;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_sad   = out_sad_q;
    assign out_max   = out_max_q;

endmodule

// File: tb/tb_abs_diff_sad.sv
// Bench for abs_diff_sad: directed scenarios plus a randomized stream
// checked against a block-level reference model (queue of expected results).
module tb_abs_diff_sad;
    localparam int W  = 8;
    localparam int BL = 4;
    localparam int AB = 2;
    localparam int SW = W + $clog2(BL);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          in_ready;
    logic          out_valid;
    logic [SW-1:0] out_sad;
    logic [W-1:0]  out_max;

    logic          in_valid1 = 1'b0;
    logic          out_ready1 = 1'b1;
    logic [W-1:0]  in_a1 = '0;
    logic [W-1:0]  in_b1 = '0;
    logic          in_ready1;
    logic          out_valid1;
    logic [W-1:0]  out_sad1;
    logic [W-1:0]  out_max1;

    abs_diff_sad #(.WIDTH(W), .BLOCK_LEN(BL), .APPROX_BITS(AB)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_sad(out_sad), .out_max(out_max));

    abs_diff_sad #(.WIDTH(W), .BLOCK_LEN(1), .APPROX_BITS(AB)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_b(in_b1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_sad(out_sad1), .out_max(out_max1));

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int part_sum = 0, part_max = 0, part_cnt = 0;
    int exp_sad[$], exp_max[$];
    int hs_sad[$], hs_max[$], hs_cyc[$];
    logic          s_valid, s_in_ready, s_acc;
    logic [SW-1:0] s_sad;
    logic [W-1:0]  s_max;
    bit            rand_rdy = 1'b0;

    function automatic int ref_diff(int a, int b);
        int am, bm;
`ifdef ABS_DIFF_APPROX_EN
        am = (a >> AB) << AB;
        bm = (b >> AB) << AB;
`else
        am = a;
        bm = b;
`endif
        return (am > bm) ? am - bm : bm - am;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, update scoreboard/model, return at posedge+1.
    task automatic cycle();
        int d;
        @(negedge clk);
        s_valid    = out_valid;
        s_in_ready = in_ready;
        s_sad      = out_sad;
        s_max      = out_max;
        s_acc      = in_valid && in_ready && !rst;
        if (rst) begin
            part_sum = 0; part_max = 0; part_cnt = 0;
            exp_sad.delete(); exp_max.delete();
        end else begin
            if (out_valid && out_ready) begin
                hs_sad.push_back(int'(out_sad));
                hs_max.push_back(int'(out_max));
                hs_cyc.push_back(cyc);
                chk("result_pending", 32'(exp_sad.size() > 0), 1);
                if (exp_sad.size() > 0) begin
                    chk("sb_sad", 32'(out_sad), exp_sad.pop_front());
                    chk("sb_max", 32'(out_max), exp_max.pop_front());
                end
            end
            if (s_acc) begin
                d = ref_diff(int'(in_a), int'(in_b));
                part_sum += d;
                if (d > part_max) part_max = d;
                part_cnt++;
                if (part_cnt == BL) begin
                    exp_sad.push_back(part_sum);
                    exp_max.push_back(part_max);
                    part_sum = 0; part_max = 0; part_cnt = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input int a, input int b);
        bit got = 1'b0;
        in_valid = 1'b1;
        in_a = W'(a);
        in_b = W'(b);
        for (int k = 0; k < 50 && !got; k++) begin
            cycle();
            got = s_acc;
            if (!got && rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
        chk("send_accepted", 32'(got), 1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 30 && exp_sad.size() > 0; k++) cycle();
        cycle();
        cycle();
        chk("drain_empty", 32'(exp_sad.size()), 0);
    endtask

    task automatic hs_clear();
        hs_sad.delete(); hs_max.delete(); hs_cyc.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int ta[4] = '{10, 200, 5, 0};
        int tb[4] = '{3, 100, 5, 255};
        bit got;

        // reset
        rst = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
        cycle();
        chk("rst_out_valid", 32'(s_valid), 0);
        chk("rst_out_sad", 32'(s_sad), 0);
        chk("rst_out_max", 32'(s_max), 0);
        chk("rst_in_ready", 32'(s_in_ready), 1);

        // single block, exact latency and one-cycle valid
        hs_clear();
        for (int i = 0; i < 4; i++) send(ta[i], tb[i]);
        in_valid = 1'b0;
        cycle();
        chk("t1_valid_early", 32'(s_valid), 0);
        cycle();
        chk("t1_valid", 32'(s_valid), 1);
        chk("t1_sad", 32'(s_sad), 362);
        chk("t1_max", 32'(s_max), 255);
        cycle();
        chk("t1_valid_drop", 32'(s_valid), 0);
        chk("t1_hs_count", 32'(hs_sad.size()), 1);

        // backpressure for 5 cycles with the next block waiting
        hs_clear();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(ta[i], tb[i]);
        in_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            cycle();
            got = s_valid;
        end
        chk("t2_valid_seen", 32'(got), 1);
        in_valid = 1'b1;
        in_a = W'(ta[0]);
        in_b = W'(tb[0]);
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("t2_in_ready_low", 32'(s_in_ready), 0);
            chk("t2_sad_hold", 32'(s_sad), 362);
            chk("t2_max_hold", 32'(s_max), 255);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(ta[i], tb[i]);
        drain();
        chk("t2_hs_count", 32'(hs_sad.size()), 2);

        // back-to-back blocks with no bubble
        hs_clear();
        for (int i = 0; i < 4; i++) send(1, 1);
        for (int i = 0; i < 4; i++) send(255, 0);
        drain();
        chk("t3_hs_count", 32'(hs_sad.size()), 2);
        if (hs_sad.size() >= 2) begin
            chk("t3_sad_a", 32'(hs_sad[0]), 0);
            chk("t3_sad_b", 32'(hs_sad[1]), 1020);
            chk("t3_max_b", 32'(hs_max[1]), 255);
            chk("t3_spacing", 32'(hs_cyc[1] - hs_cyc[0]), 4);
        end

        // reset mid-block drops the partial block
        hs_clear();
        send(60, 10);
        send(60, 10);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) send(1, 2);
        drain();
        chk("t4_hs_count", 32'(hs_sad.size()), 1);
        if (hs_sad.size() >= 1) begin
            chk("t4_sad", 32'(hs_sad[0]), 4);
            chk("t4_max", 32'(hs_max[0]), 1);
        end

        // operand truncation (or exact result in the default build)
        hs_clear();
        for (int i = 0; i < 4; i++) send(7, 2);
        drain();
        chk("t5_hs_count", 32'(hs_sad.size()), 1);
        if (hs_sad.size() >= 1) begin
`ifdef ABS_DIFF_APPROX_EN
            chk("t5_sad", 32'(hs_sad[0]), 16);
            chk("t5_max", 32'(hs_max[0]), 4);
`else
            chk("t5_sad", 32'(hs_sad[0]), 20);
            chk("t5_max", 32'(hs_max[0]), 5);
`endif
        end

        // randomized stream with random gaps and backpressure
        rand_rdy = 1'b1;
        for (int n = 0; n < 300; n++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) == 0) begin
                in_valid = 1'b0;
                cycle();
            end else begin
                send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            end
        end
        rand_rdy = 1'b0;
        // finish any partial block so every expected result is observed
        while (part_cnt != 0) send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        drain();

        // BLOCK_LEN = 1: every sample is its own block
        @(negedge clk);
        in_valid1 = 1'b1; in_a1 = 8'd0; in_b1 = 8'd9;
        @(posedge clk); #1;
        in_a1 = 8'd9; in_b1 = 8'd0;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        @(negedge clk);
        chk("bl1_valid0", 32'(out_valid1), 1);
        chk("bl1_sad0", 32'(out_sad1), 9);
        @(negedge clk);
        chk("bl1_valid1", 32'(out_valid1), 1);
        chk("bl1_sad1", 32'(out_sad1), 9);
        chk("bl1_max1", 32'(out_max1), 9);
        @(negedge clk);
        chk("bl1_valid_drop", 32'(out_valid1), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
